mux_rr_arbiter: RTL and testbench
=================================

# mux_rr_arbiter

Round-robin controller that shares one W-bit N:1 output mux among N valid/ready requesters. It picks one active requester, holds the mux select on that requester until its word is accepted downstream, then moves priority to the next index. It is the sequencing layer above the combinational mux primitives in the combinational-logic section, and is the first block there with registered state.

## Interface
- N, 4, number of requesters (2..16, need not be a power of two)
- W, 8, data width per requester
- SW, $clog2(N), select width (derived, not overridable)

- clk  input  1  sole clock, rising edge
- rst  input  1  synchronous, active-high reset
- req_vld  input  N  per-requester valid; bit k belongs to requester k
- req_data  input  N*W  flattened data; requester k occupies bits [k*W +: W]
- req_rdy  output  N  per-requester accept, one-hot or zero
- out_vld  output  1  downstream valid
- out_data  output  W  downstream data, driven through the mux
- out_rdy  input  1  downstream ready
- sel  output  SW  current mux select (registered), for debug/observability

## Operation
- FSM with two states:
  - IDLE: no grant. out_vld=0, req_rdy=0, out_data=0.
  - GRANT: requester sel owns the mux.
- Priority pointer ptr (SW bits) holds the highest-priority index.
- IDLE → GRANT when any req_vld bit is set.
  - sel ← first k with req_vld[k]=1, searching ptr, ptr+1, … with wrap mod N.
  - The search wraps mod N, never mod 2^SW. Indices ≥ N are never selected.
- In GRANT:
  - out_vld = req_vld[sel]
  - out_data = req_data[sel]
  - req_rdy[sel] = out_rdy; all other req_rdy bits are 0.
- Handshake (out_vld && out_rdy) in GRANT:
  - Transfer completes that cycle.
  - ptr ← (sel+1) mod N.
  - State → IDLE.
- req_vld[sel] drops while in GRANT, without a handshake:
  - Treated as a protocol violation.
  - State → IDLE; ptr is unchanged, so the same index keeps top priority.
- Requesters must hold req_vld and req_data stable until their req_rdy is seen high.
- out_rdy low in GRANT: the state holds indefinitely. There is no timeout and no pre-emption.
- Requests that arrive during GRANT are not considered until the next IDLE cycle.
- Reset (any cycle, including mid-GRANT with out_vld high):
  - state=IDLE, ptr=0, sel=0
  - out_vld=0, req_rdy=0, out_data=0 from the next cycle on
  - Any pending transfer is abandoned.

## Timing
- Grant latency: request seen in IDLE at cycle t → sel registered at edge t+1 → out_vld=1 during cycle t+1.
- Accept latency: zero cycles. out_rdy reaches req_rdy[sel] combinationally; out_vld/out_data follow req_vld/req_data combinationally in GRANT.
- Peak throughput is one transfer per 2 cycles (GRANT, IDLE, GRANT, …).
- All state (state, ptr, sel) updates only on the rising edge of clk.
- Outputs are combinational from registered state plus req_* and out_rdy. There is no combinational path from out_rdy to out_vld.
- Fairness: with all N requesters continuously valid, each is granted exactly once per N transfers, in index order starting from ptr.

## Structure
- Shared package mux_arb_pkg:
  - typedef enum logic {IDLE, GRANT} arb_state_t
  - function rr_pick(vld, ptr), returning the first set index at or after ptr, mod N
- One sub-module, mux_n: combinational N:1 mux of W-bit words indexed by sel, built from the existing 2:1 mux style.
- The arbiter instantiates mux_n once for out_data. The arbiter owns the FSM, ptr and the handshake gating.

## Test plan
- Reset mid-GRANT: assert rst one cycle while out_vld=1 → next cycle out_vld=0, req_rdy=0, sel=0, out_data=0; with req_vld=4'b1000 afterwards, sel=3 on the following grant.
- Single requester: req_vld=4'b0100, req_data[2]=8'hA5, out_rdy=1 → out_vld=1 with out_data=8'hA5 and req_rdy=4'b0100 one cycle after request; IDLE the cycle after; ptr=3.
- Round-robin with all valid: req_vld=4'b1111, out_rdy=1 for 16 cycles → grant order 0,1,2,3,0,1,2,3, one handshake every 2 cycles.
- Back-pressure: grant requester 1, hold out_rdy=0 for 5 cycles → out_vld and out_data stable, req_rdy=0, sel=1 throughout; the handshake fires on the first out_rdy=1 cycle.
- Non-power-of-two wrap: N=3, ptr=2, req_vld=3'b011 → sel=0 (never 3), then ptr=1.
- Valid drop: grant requester 2, deassert req_vld[2] before out_rdy → IDLE next cycle, ptr unchanged; re-asserting req_vld[2] together with req_vld[3] → requester 2 granted first.

Source files
------------

// File: rtl/mux_arb_pkg.sv
// Shared types and the round-robin search used by the mux arbiter.
// The search is sized for the largest supported requester count (16).
package mux_arb_pkg;

    typedef enum logic {IDLE, GRANT} arb_state_t;

    localparam int MAX_N  = 16;
    localparam int MAX_SW = 4;

    // First set bit of vld at or after ptr, wrapping modulo n (not modulo 2^MAX_SW).
    function automatic logic [MAX_SW-1:0] rr_pick(input logic [MAX_N-1:0]  vld,
                                                  input logic [MAX_SW-1:0] ptr,
                                                  input int                n);
        logic [MAX_SW-1:0] pick;
        logic              found;
        int                idx;
        pick  = '0;
        found = 1'b0;
        for (int i = 0; i < MAX_N; i++) begin
            if (i < n) begin
                idx = int'(ptr) + i;
                if (idx >= n) idx = idx - n;
                if (!found && vld[idx[MAX_SW-1:0]]) begin
                    pick  = MAX_SW'(idx);
                    found = 1'b1;
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/mux_n.sv
// Combinational N:1 mux of W-bit words, written as a chain of 2:1 selections.
// Select values at or above N produce zero.
module mux_n #(
    parameter int N = 4,
    parameter int W = 8,
    localparam int SW = $clog2(N)
) (
    input  logic [SW-1:0]  sel,
    input  logic [N*W-1:0] data,
    output logic [W-1:0]   y
);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        y = '0;
        for (int k = 0; k < N; k++) begin
            y = (sel == SW'(k)) ? data[k*W +: W] : y;
        end
    end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter owning one shared N:1 data mux between N valid/ready
// requesters; the grant is held until the selected word is accepted downstream.
module mux_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int N = 4,
    parameter int W = 8,
    localparam int SW = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req_vld,
    input  logic [N*W-1:0] req_data,
    output logic [N-1:0]   req_rdy,
    output logic           out_vld,
    output logic [W-1:0]   out_data,
    input  logic           out_rdy,
    output logic [SW-1:0]  sel
);

    arb_state_t       state, state_nxt;
    logic [SW-1:0]    ptr, ptr_nxt;
    logic [SW-1:0]    sel_nxt;
    logic [MAX_N-1:0] vld_ext;
    logic [W-1:0]     mux_y;
    logic             grant;

    // NOTE: sequential state uses non-blocking assignments; reset is synchronous here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ptr   <= '0;
            sel   <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            sel   <= sel_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        sel_nxt   = sel;
        vld_ext   = '0;
        vld_ext[N-1:0] = req_vld;
        case (state)
            IDLE: begin
                if (|req_vld) begin
                    state_nxt = GRANT;
                    sel_nxt   = SW'(rr_pick(vld_ext, MAX_SW'(ptr), N));
                end
            end
            GRANT: begin
                // A dropped valid abandons the grant but keeps ptr, so the same index stays first.
                if (!req_vld[sel]) begin
                    state_nxt = IDLE;
                end else if (out_rdy) begin
                    state_nxt = IDLE;
                    ptr_nxt   = (sel == SW'(N - 1)) ? '0 : sel + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    mux_n #(.N(N), .W(W)) u_mux (
        .sel  (sel),
        .data (req_data),
        .y    (mux_y)
    );

    assign grant    = (state == GRANT);
    assign out_vld  = grant && req_vld[sel];
    assign out_data = grant ? mux_y : '0;
    assign req_rdy  = grant ? (N'(out_rdy) << sel) : '0;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed, table-driven bench for mux_rr_arbiter (N=4 main instance, N=3 wrap instance).
module tb_mux_rr_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  a_vld;
    logic [31:0] a_data;
    logic [3:0]  a_rdy;
    logic        a_ovld;
    logic [7:0]  a_odata;
    logic        a_ordy;
    logic [1:0]  a_sel;

    logic [2:0]  b_vld;
    logic [23:0] b_data;
    logic [2:0]  b_rdy;
    logic        b_ovld;
    logic [7:0]  b_odata;
    logic        b_ordy;
    logic [1:0]  b_sel;

    int n_checks;
    int n_fail;

    mux_rr_arbiter #(.N(4), .W(8)) dut_a (
        .clk(clk), .rst(rst), .req_vld(a_vld), .req_data(a_data), .req_rdy(a_rdy),
        .out_vld(a_ovld), .out_data(a_odata), .out_rdy(a_ordy), .sel(a_sel)
    );

    mux_rr_arbiter #(.N(3), .W(8)) dut_b (
        .clk(clk), .rst(rst), .req_vld(b_vld), .req_data(b_data), .req_rdy(b_rdy),
        .out_vld(b_ovld), .out_data(b_odata), .out_rdy(b_ordy), .sel(b_sel)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [3:0] vld;
        logic       rdy;
        logic       exp_vld;
        logic [7:0] exp_data;
        logic [3:0] exp_rdy;
        logic [1:0] exp_sel;
    } vec_t;

    vec_t vecs [32];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_a(input string tag, input logic [3:0] vld, input logic rdy,
                           input logic ev, input logic [7:0] ed, input logic [3:0] er,
                           input logic [1:0] es);
        a_vld  = vld;
        a_ordy = rdy;
        #1;
        check({tag, ".out_vld"},  32'(a_ovld),  32'(ev));
        check({tag, ".out_data"}, 32'(a_odata), 32'(ed));
        check({tag, ".req_rdy"},  32'(a_rdy),   32'(er));
        check({tag, ".sel"},      32'(a_sel),   32'(es));
    endtask

    task automatic apply_b(input string tag, input logic [2:0] vld, input logic rdy,
                           input logic ev, input logic [7:0] ed, input logic [2:0] er,
                           input logic [1:0] es);
        b_vld  = vld;
        b_ordy = rdy;
        #1;
        check({tag, ".out_vld"},  32'(b_ovld),  32'(ev));
        check({tag, ".out_data"}, 32'(b_odata), 32'(ed));
        check({tag, ".req_rdy"},  32'(b_rdy),   32'(er));
        check({tag, ".sel"},      32'(b_sel),   32'(es));
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        // Requester words: 0=C3, 1=5A, 2=A5, 3=3C (N=3 instance: 0=11, 1=22, 2=33).
        a_data = 32'h3C_A5_5A_C3;
        b_data = 24'h33_22_11;
        a_vld = '0; a_ordy = 1'b0;
        b_vld = '0; b_ordy = 1'b0;

        // vld, rdy, exp_vld, exp_data, exp_rdy, exp_sel
        vecs[0]  = '{4'b0100, 1'b1, 1'b0, 8'h00, 4'b0000, 2'd0};  // single requester
        vecs[1]  = '{4'b0100, 1'b1, 1'b1, 8'hA5, 4'b0100, 2'd2};
        vecs[2]  = '{4'b0000, 1'b1, 1'b0, 8'h00, 4'b0000, 2'd2};
        vecs[3]  = '{4'b1111, 1'b1, 1'b0, 8'h00, 4'b0000, 2'd2};  // all valid, ptr=3
        vecs[4]  = '{4'b1111, 1'b1, 1'b1, 8'h3C, 4'b1000, 2'd3};
        vecs[5]  = '{4'b1111, 1'b1, 1'b0, 8'h00, 4'b0000, 2'd3};
        vecs[6]  = '{4'b1111, 1'b1, 1'b1, 8'hC3, 4'b0001, 2'd0};
        vecs[7]  = '{4'b1111, 1'b1, 1'b0, 8'h00, 4'b0000, 2'd0};
        vecs[8]  = '{4'b1111, 1'b1, 1'b1, 8'h5A, 4'b0010, 2'd1};
        vecs[9]  = '{4'b1111, 1'b1, 1'b0, 8'h00, 4'b0000, 2'd1};
        vecs[10] = '{4'b1111, 1'b1, 1'b1, 8'hA5, 4'b0100, 2'd2};
        vecs[11] = '{4'b1111, 1'b1, 1'b0, 8'h00, 4'b0000, 2'd2};
        vecs[12] = '{4'b1111, 1'b1, 1'b1, 8'h3C, 4'b1000, 2'd3};
        vecs[13] = '{4'b1111, 1'b1, 1'b0, 8'h00, 4'b0000, 2'd3};
        vecs[14] = '{4'b1111, 1'b1, 1'b1, 8'hC3, 4'b0001, 2'd0};
        vecs[15] = '{4'b0010, 1'b0, 1'b0, 8'h00, 4'b0000, 2'd0};  // back-pressure
        vecs[16] = '{4'b0010, 1'b0, 1'b1, 8'h5A, 4'b0000, 2'd1};
        vecs[17] = '{4'b0010, 1'b0, 1'b1, 8'h5A, 4'b0000, 2'd1};
        vecs[18] = '{4'b0010, 1'b0, 1'b1, 8'h5A, 4'b0000, 2'd1};
        vecs[19] = '{4'b0010, 1'b0, 1'b1, 8'h5A, 4'b0000, 2'd1};
        vecs[20] = '{4'b0010, 1'b0, 1'b1, 8'h5A, 4'b0000, 2'd1};
        vecs[21] = '{4'b0010, 1'b1, 1'b1, 8'h5A, 4'b0010, 2'd1};
        vecs[22] = '{4'b0000, 1'b0, 1'b0, 8'h00, 4'b0000, 2'd1};
        vecs[23] = '{4'b0100, 1'b0, 1'b0, 8'h00, 4'b0000, 2'd1};  // valid drop
        vecs[24] = '{4'b0100, 1'b0, 1'b1, 8'hA5, 4'b0000, 2'd2};
        vecs[25] = '{4'b0000, 1'b0, 1'b0, 8'hA5, 4'b0000, 2'd2};
        vecs[26] = '{4'b1100, 1'b0, 1'b0, 8'h00, 4'b0000, 2'd2};
        vecs[27] = '{4'b1100, 1'b1, 1'b1, 8'hA5, 4'b0100, 2'd2};
        vecs[28] = '{4'b1100, 1'b1, 1'b0, 8'h00, 4'b0000, 2'd2};
        vecs[29] = '{4'b1100, 1'b1, 1'b1, 8'h3C, 4'b1000, 2'd3};
        vecs[30] = '{4'b1000, 1'b0, 1'b0, 8'h00, 4'b0000, 2'd3};
        vecs[31] = '{4'b1000, 1'b0, 1'b1, 8'h3C, 4'b0000, 2'd3};

        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        apply_a("reset_a", 4'b0000, 1'b0, 1'b0, 8'h00, 4'b0000, 2'd0);
        apply_b("reset_b", 3'b000, 1'b0, 1'b0, 8'h00, 3'b000, 2'd0);

        for (int i = 0; i < 32; i++) begin
            apply_a($sformatf("vec%0d", i), vecs[i].vld, vecs[i].rdy, vecs[i].exp_vld,
                    vecs[i].exp_data, vecs[i].exp_rdy, vecs[i].exp_sel);
            tick();
        end

        // Drop valid on the held grant, then move ptr to 2 before a mid-grant reset.
        apply_a("h0", 4'b0010, 1'b0, 1'b0, 8'h3C, 4'b0000, 2'd3); tick();
        apply_a("h1", 4'b0010, 1'b0, 1'b0, 8'h00, 4'b0000, 2'd3); tick();
        apply_a("h2", 4'b0010, 1'b1, 1'b1, 8'h5A, 4'b0010, 2'd1); tick();
        apply_a("h3", 4'b1000, 1'b0, 1'b0, 8'h00, 4'b0000, 2'd1); tick();
        apply_a("h4", 4'b1000, 1'b0, 1'b1, 8'h3C, 4'b0000, 2'd3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        apply_a("rst_mid", 4'b1010, 1'b0, 1'b0, 8'h00, 4'b0000, 2'd0); tick();
        apply_a("post_rst", 4'b1010, 1'b0, 1'b1, 8'h5A, 4'b0000, 2'd1); tick();
        a_vld = '0;

        // N=3: move ptr to 2, then request {1,0}; the search must wrap to 0, never 3.
        apply_b("b0", 3'b010, 1'b1, 1'b0, 8'h00, 3'b000, 2'd0); tick();
        apply_b("b1", 3'b010, 1'b1, 1'b1, 8'h22, 3'b010, 2'd1); tick();
        apply_b("b2", 3'b011, 1'b1, 1'b0, 8'h00, 3'b000, 2'd1); tick();
        apply_b("b3", 3'b011, 1'b1, 1'b1, 8'h11, 3'b001, 2'd0); tick();
        apply_b("b4", 3'b011, 1'b1, 1'b0, 8'h00, 3'b000, 2'd0); tick();
        apply_b("b5", 3'b011, 1'b1, 1'b1, 8'h22, 3'b010, 2'd1); tick();
        b_vld = '0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
